if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the MIPS core; sits directly upstream of the control unit and the register file.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds the fetched instruction and PC+4 for decode; ID_OP feeds the control unit's opcode input.
- Supports a hazard-unit stall and a branch/jump redirect that flushes the IF/ID slot.

---
 rtl/mips_fetch_pkg.sv | 22 ++
 rtl/if_id_register.sv | 54 +++++
 rtl/if_id_fetch_stage.sv | 129 ++++++++++++
 tb/tb_if_id_fetch_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch state encoding, reset
// defaults and opcode field bounds.
package mips_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t RST_HOLD = 2'd0;
  localparam fetch_state_t FETCH    = 2'd1;
  localparam fetch_state_t KILL     = 2'd2;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  // Branch/jump targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush (to NOP, invalid) beats load, otherwise hold.
module if_id_register
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcplus4_in,
  output logic [31:0] instr,
  output logic [31:0] pcplus4,
  output logic        valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pcplus4_d, pcplus4_q;
  logic        valid_d, valid_q;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d   = instr_in;
      pcplus4_d = pcplus4_in;
      valid_d   = 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr   = instr_q;
  assign pcplus4 = pcplus4_q;
  assign valid   = valid_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// MIPS instruction fetch stage with IF/ID register, req/ack instruction memory
// port, stall and redirect. Define FETCH_STATS_EN to add fetch/squash counters.
module if_id_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_RData,
  input  logic        IMem_Ack,
  output logic [31:0] PC,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic [5:0]  ID_OP
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] SquashCount
`endif
);

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  kill_addr_d, kill_addr_q;
  logic         req, ack_eff, redirect_eff, load, flush;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    req          = 1'b0;
    load         = 1'b0;
    flush        = 1'b0;
    case (state_q)
      RST_HOLD: state_d = FETCH;
      FETCH:    req = !(IF_Stall && ID_Valid);
      KILL:     req = 1'b1;
      default:  state_d = FETCH;
    endcase
    ack_eff      = IMem_Ack && req;
    redirect_eff = Redirect && (state_q != RST_HOLD);

    if (redirect_eff) begin
      pc_d  = align_pc(RedirectPC);
      flush = 1'b1;
      // An outstanding request must still complete at its old address.
      if (req && !IMem_Ack) begin
        state_d = KILL;
        if (state_q == FETCH) kill_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else if (state_q == FETCH) begin
      if (ack_eff) begin
        load = 1'b1;
        pc_d = pc_q + 32'd4;
      end else if (!IF_Stall) begin
        flush = 1'b1;
      end
    end else if (state_q == KILL && IMem_Ack) begin
      state_d = FETCH;
    end
  end

  // NOTE: the address/data flops are reset too, so nothing downstream ever sees X after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RST_HOLD;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
    end
  end

  assign IMem_Req  = req;
  assign IMem_Addr = (state_q == KILL) ? kill_addr_q : pc_q;
  assign PC        = pc_q;

  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (reset),
    .load       (load),
    .flush      (flush),
    .instr_in   (IMem_RData),
    .pcplus4_in (pc_q + 32'd4),
    .instr      (ID_Instruction),
    .pcplus4    (ID_PCPlus4),
    .valid      (ID_Valid)
  );

  assign ID_OP = ID_Instruction[OP_MSB:OP_LSB];

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_d, fetch_count_q;
  logic [31:0] squash_count_d, squash_count_q;

  always_comb begin
    fetch_count_d  = fetch_count_q;
    squash_count_d = squash_count_q;
    if (load) fetch_count_d = fetch_count_q + 32'd1;
    if (redirect_eff && (ID_Valid || ack_eff)) squash_count_d = squash_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign FetchCount  = fetch_count_q;
  assign SquashCount = squash_count_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage; accepted fetches are
// scoreboarded and compared when they appear in IF/ID.
module tb_if_id_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk, reset, IF_Stall, Redirect, IMem_Ack;
  logic [31:0] RedirectPC, IMem_RData;
  logic        IMem_Req, ID_Valid;
  logic [31:0] IMem_Addr, PC, ID_Instruction, ID_PCPlus4;
  logic [5:0]  ID_OP;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount, SquashCount;
`endif

  int   errors = 0;
  int   checks = 0;
  int   exp_fetches = 0;
  exp_t sb_q[$];

  if_id_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IF_Stall       (IF_Stall),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .IMem_Req       (IMem_Req),
    .IMem_Addr      (IMem_Addr),
    .IMem_RData     (IMem_RData),
    .IMem_Ack       (IMem_Ack),
    .PC             (PC),
    .ID_Instruction (ID_Instruction),
    .ID_PCPlus4     (ID_PCPlus4),
    .ID_Valid       (ID_Valid),
    .ID_OP          (ID_OP)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount     (FetchCount),
    .SquashCount    (SquashCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait fetch at exp_addr; the expected IF/ID contents go through the scoreboard.
  task automatic fetch_ok(input logic [31:0] data, input logic [31:0] exp_addr, input string tag);
    exp_t e;
    IMem_Ack   = 1'b1;
    IMem_RData = data;
    #1;
    chk({tag, "_req"}, {31'd0, IMem_Req}, 32'd1);
    chk({tag, "_addr"}, IMem_Addr, exp_addr);
    sb_q.push_back('{instr: data, pc4: exp_addr + 32'd4});
    exp_fetches++;
    step();
    IMem_Ack = 1'b0;
    e = sb_q.pop_front();
    chk({tag, "_instr"}, ID_Instruction, e.instr);
    chk({tag, "_pc4"}, ID_PCPlus4, e.pc4);
    chk({tag, "_valid"}, {31'd0, ID_Valid}, 32'd1);
    chk({tag, "_op"}, {26'd0, ID_OP}, {26'd0, e.instr[31:26]});
    chk({tag, "_pc"}, PC, exp_addr + 32'd4);
  endtask

  initial begin
    reset = 1'b1; IF_Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    IMem_Ack = 1'b0; IMem_RData = '0;
    #1 reset = 1'b0;
    step(); step();
    chk("rst_pc", PC, 32'h0040_0000);
    chk("rst_valid", {31'd0, ID_Valid}, 32'd0);
    chk("rst_instr", ID_Instruction, 32'h0);
    chk("rst_pc4", ID_PCPlus4, 32'h0);
    chk("rst_req", {31'd0, IMem_Req}, 32'd0);

    reset = 1'b1;
    #1;
    chk("hold_req", {31'd0, IMem_Req}, 32'd0);
    step();

    // Back-to-back zero-wait fetches
    fetch_ok(32'h2008_0005, 32'h0040_0000, "f0");
    fetch_ok(32'h3409_000F, 32'h0040_0004, "f1");

    // Stall with a valid slot; a stray Ack must be ignored
    IF_Stall = 1'b1; IMem_Ack = 1'b1; IMem_RData = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", {31'd0, IMem_Req}, 32'd0);
      step();
      chk("stall_pc", PC, 32'h0040_0008);
      chk("stall_instr", ID_Instruction, 32'h3409_000F);
      chk("stall_valid", {31'd0, ID_Valid}, 32'd1);
    end
    IF_Stall = 1'b0; IMem_Ack = 1'b0;
    fetch_ok(32'h8C0A_0000, 32'h0040_0008, "f2");

    // Redirect in a zero-wait Ack cycle
    Redirect = 1'b1; RedirectPC = 32'h0040_0103;
    IMem_Ack = 1'b1; IMem_RData = 32'hDEAD_BEEF;
    #1;
    chk("rz_addr", IMem_Addr, 32'h0040_000C);
    step();
    Redirect = 1'b0; IMem_Ack = 1'b0;
    chk("rz_valid", {31'd0, ID_Valid}, 32'd0);
    chk("rz_instr", ID_Instruction, 32'h0);
    chk("rz_pc", PC, 32'h0040_0100);
    #1;
    chk("rz_next_addr", IMem_Addr, 32'h0040_0100);
    chk("rz_next_req", {31'd0, IMem_Req}, 32'd1);

    // Slow memory: redirect in wait cycle 1, stale word returns on wait cycle 3
    Redirect = 1'b1; RedirectPC = 32'h0040_0200;
    step();
    Redirect = 1'b0;
    chk("kill_req", {31'd0, IMem_Req}, 32'd1);
    chk("kill_addr", IMem_Addr, 32'h0040_0100);
    chk("kill_pc", PC, 32'h0040_0200);
    step();
    chk("kill_addr2", IMem_Addr, 32'h0040_0100);
    IMem_Ack = 1'b1; IMem_RData = 32'hBAAD_F00D;
    step();
    IMem_Ack = 1'b0;
    chk("kill_drop_valid", {31'd0, ID_Valid}, 32'd0);
    chk("kill_drop_instr", ID_Instruction, 32'h0);
    chk("kill_tgt_addr", IMem_Addr, 32'h0040_0200);
    chk("kill_tgt_req", {31'd0, IMem_Req}, 32'd1);
    fetch_ok(32'h2402_0001, 32'h0040_0200, "f3");

    // Wait cycle without stall inserts a bubble
    step();
    chk("bubble_valid", {31'd0, ID_Valid}, 32'd0);
    chk("bubble_instr", ID_Instruction, 32'h0);
    chk("bubble_addr", IMem_Addr, 32'h0040_0204);

    // PC wrap
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    IMem_Ack = 1'b1; IMem_RData = 32'h1234_5678;
    step();
    Redirect = 1'b0; IMem_Ack = 1'b0;
    chk("wrap_pc_pre", PC, 32'hFFFF_FFFC);
    fetch_ok(32'h0810_0000, 32'hFFFF_FFFC, "fw");
    chk("wrap_pc4", ID_PCPlus4, 32'h0);

    fetch_ok(32'h3C01_1000, 32'h0000_0000, "f4");
`ifdef FETCH_STATS_EN
    chk("stats_fetch", FetchCount, exp_fetches);
    chk("stats_squash", SquashCount, 32'd2);
`endif

    // Asynchronous reset in the middle of a wait cycle
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, IMem_Req}, 32'd0);
    chk("mid_rst_pc", PC, 32'h0040_0000);
    chk("mid_rst_valid", {31'd0, ID_Valid}, 32'd0);
    chk("mid_rst_instr", ID_Instruction, 32'h0);
    chk("mid_rst_pc4", ID_PCPlus4, 32'h0);
`ifdef FETCH_STATS_EN
    chk("mid_rst_fetch", FetchCount, 32'h0);
    chk("mid_rst_squash", SquashCount, 32'h0);
`endif
    step();
    reset = 1'b1;
    step();
    fetch_ok(32'h2008_0005, 32'h0040_0000, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
